galaxian_load_ctrl: RTL and testbench
=====================================

// Module: galaxian_load_ctrl
// PURPOSE
//  Sequences the HPS ioctl download stream into the Galaxian-family core and owns the core reset.
//  - Decodes ROM bytes into CPU / GFX / PROM write strobes.
//  - Latches the game-select byte and the 8 DIP/switch bytes.
//  - Holds the core in reset until a complete ROM image has loaded, then stretches reset for RESET_HOLD cycles.
//  - Sits between hps_io and the galaxian core in the emu top level.
// PARAMETERS
//  ROM_INDEX   8'd0      ioctl_index carrying the ROM image
//  MOD_INDEX   8'd1      ioctl_index carrying the game-select byte
//  DIP_INDEX   8'd254    ioctl_index carrying the DIP bytes
//  CPU_END     16'h4000  first address past the CPU ROM region
//  GFX_END     16'h5000  first address past the GFX ROM region
//  PROM_END    16'h5020  first address past the colour PROM region (image size)
//  RESET_HOLD  16        core-reset stretch in clk_sys cycles (>=1)
// PORTS
//  clk_sys        in   1   system clock (12 MHz)
//  RESET          in   1   asynchronous, active-high reset
//  ioctl_download in   1   download in progress
//  ioctl_wr       in   1   byte strobe, one clk_sys wide
//  ioctl_index    in   8   download stream index
//  ioctl_addr     in   25  byte address within the stream
//  ioctl_dout     in   8   byte data
//  user_reset     in   1   OSD reset / user button request
//  dn_addr        out  16  region-relative write address
//  dn_data        out  8   write data
//  cpu_we         out  1   CPU ROM write strobe
//  gfx_we         out  1   GFX ROM write strobe
//  prom_we        out  1   PROM write strobe
//  mod_id         out  8   latched game-select byte
//  sw_flat        out  64  DIP bytes; sw[n] = sw_flat[8n+7:8n]
//  core_reset     out  1   reset to the game core
//  rom_ok         out  1   last ROM download was complete
//  rom_err        out  1   last ROM download was short or overran PROM_END
// BEHAVIOUR
//  Reset values
//  - RESET asserted: all outputs 0 except core_reset=1; state=IDLE; hold counter=0.
//  States
//  - IDLE: core_reset=1.
//    - ioctl_download with any index -> LOAD.
//    - Otherwise remain in IDLE.
//  - LOAD: core_reset=1; accept writes.
//    - Falling edge of ioctl_download, ROM_INDEX stream:
//      - last byte (PROM_END-1) seen and no overrun -> rom_ok=1, rom_err=0, HOLD.
//      - otherwise -> rom_ok=0, rom_err=1, IDLE.
//    - Falling edge of ioctl_download, other index:
//      - rom_ok=1 -> HOLD.
//      - rom_ok=0 -> IDLE.
//  - HOLD: core_reset=1; counter counts RESET_HOLD cycles, then RUN.
//    - ioctl_download -> LOAD; the counter clears.
//  - RUN: core_reset=0.
//    - user_reset -> HOLD; counter cleared.
//    - ioctl_download -> LOAD.
//    - If both occur in the same cycle, LOAD takes priority.
//  - On entering LOAD for ROM_INDEX: rom_ok and rom_err clear to 0 and the last-byte flag clears.
//  ROM write path
//  - Registered; latency 1 cycle from ioctl_wr to a strobe.
//  - Each strobe is exactly 1 cycle wide, and at most one strobe is high.
//  - Region decode on a = ioctl_addr[15:0]:
//    - a < CPU_END: cpu_we, dn_addr = a.
//    - CPU_END <= a < GFX_END: gfx_we, dn_addr = a - CPU_END.
//    - GFX_END <= a < PROM_END: prom_we, dn_addr = a - GFX_END.
//  - Overrun: ioctl_addr[24:16] != 0, or a >= PROM_END.
//    - No strobe is issued and an overrun flag is set; the overrun makes the download end with rom_err=1.
//  - dn_data = ioctl_dout registered alongside the strobe.
//  - dn_addr and dn_data hold their values between strobes.
//  Game-select path
//  - MOD_INDEX write: mod_id <= ioctl_dout.
//  - The last byte written wins; ioctl_addr is ignored.
//  DIP path
//  - DIP_INDEX write with ioctl_addr[24:3]==0 updates sw[ioctl_addr[2:0]].
//  - Higher addresses are ignored.
//  - sw_flat persists across ROM reloads and across user_reset; only RESET clears it.
//  General rules
//  - ioctl_wr with ioctl_download=0 is ignored.
//  - ioctl_wr during a download whose index is not ROM_INDEX, MOD_INDEX or DIP_INDEX is ignored.
//  - ioctl_index is sampled at the rising edge of ioctl_download and held for the whole download.
//    A change of index mid-download is ignored.
//  - RESET mid-download aborts it: IDLE, rom_ok=0. Bytes already written stay in the ROMs.
// TESTING
//  1. Release RESET, no download -> core_reset stays 1, rom_ok=0, no strobes for 1000 cycles.
//  2. Full ROM_INDEX download 0x0000..0x501F:
//     - cpu_we x16384, gfx_we x4096, prom_we x32.
//     - Byte 0x4000 -> gfx_we with dn_addr=0.
//     - Byte 0x501F -> prom_we with dn_addr=0x1F.
//     - rom_ok=1, rom_err=0, and core_reset falls exactly RESET_HOLD cycles after ioctl_download falls.
//  3. ROM download stopping at 0x3FFF -> rom_err=1, rom_ok=0, core_reset remains 1.
//  4. Download containing address 0x5020 or 0x10000 -> no strobe for that byte; rom_err=1 at the end.
//  5. After case 2 in RUN:
//     - DIP_INDEX writes addr 2 = 0xA5 and addr 9 = 0xFF -> sw_flat[23:16]=0xA5, other bytes unchanged.
//     - MOD_INDEX byte 0x0A -> mod_id=0x0A.
//     - core_reset is 1 during each download and returns to 0 after RESET_HOLD.
//  6. In RUN, pulse user_reset for 1 cycle -> core_reset=1 for RESET_HOLD cycles.
//     Assert RESET mid-ROM-download -> core_reset=1, rom_ok=0, IDLE, sw_flat=0.

Source files
------------

// File: rtl/galaxian_load_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | galaxian_load_ctrl                                                         |
// | Routes the ioctl download stream to ROM/PROM, game-select and DIP stores   |
// | and owns the core reset sequence.                                          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module galaxian_load_ctrl #(
    parameter logic [7:0]  ROM_INDEX  = 8'd0,
    parameter logic [7:0]  MOD_INDEX  = 8'd1,
    parameter logic [7:0]  DIP_INDEX  = 8'd254,
    parameter logic [15:0] CPU_END    = 16'h4000,
    parameter logic [15:0] GFX_END    = 16'h5000,
    parameter logic [15:0] PROM_END   = 16'h5020,
    parameter int unsigned RESET_HOLD = 16
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_index,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        user_reset,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        cpu_we,
    output logic        gfx_we,
    output logic        prom_we,
    output logic [7:0]  mod_id,
    output logic [63:0] sw_flat,
    output logic        core_reset,
    output logic        rom_ok,
    output logic        rom_err
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_load = 2'd1;
    localparam logic [1:0] c_st_hold = 2'd2;
    localparam logic [1:0] c_st_run  = 2'd3;

    localparam int unsigned          c_hold_w    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [c_hold_w-1:0]  c_hold_last = c_hold_w'(RESET_HOLD - 1);

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic                r_dl_d;
    logic [7:0]          r_index;
    logic [7:0]          w_cur_index;
    logic [c_hold_w-1:0] r_hold_cnt;
    logic                r_last_seen;
    logic                r_overrun;
    logic                w_wr;
    logic                w_rom_wr;
    logic                w_hi_nz;
    logic                w_in_image;
    logic                w_overrun;
    logic                w_last_hit;
    logic                w_load_good;
    logic                w_rom_start;
    logic [15:0]         w_a;

    // The index is captured on the first download cycle so the byte that arrives
    // with the rising edge is already routed by the new stream.
    assign w_cur_index = (ioctl_download && !r_dl_d) ? ioctl_index : r_index;
    assign w_wr        = ioctl_download && ioctl_wr;
    assign w_rom_wr    = w_wr && (w_cur_index == ROM_INDEX);
    assign w_a         = ioctl_addr[15:0];
    assign w_hi_nz     = |ioctl_addr[24:16];
    assign w_in_image  = !w_hi_nz && (w_a < PROM_END);
    assign w_overrun   = w_rom_wr && !w_in_image;
    assign w_last_hit  = w_rom_wr && !w_hi_nz && (w_a == PROM_END - 16'd1);
    assign w_load_good = r_last_seen && !r_overrun;
    assign w_rom_start = (r_state != c_st_load) && (w_next_state == c_st_load)
                         && (w_cur_index == ROM_INDEX);
    assign core_reset  = (r_state != c_st_run);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (ioctl_download) w_next_state = c_st_load;
            end
            c_st_load: begin
                if (!ioctl_download) begin
                    if (r_index == ROM_INDEX) w_next_state = w_load_good ? c_st_hold : c_st_idle;
                    else                      w_next_state = rom_ok ? c_st_hold : c_st_idle;
                end
            end
            c_st_hold: begin
                if (ioctl_download)                 w_next_state = c_st_load;
                else if (r_hold_cnt == c_hold_last) w_next_state = c_st_run;
            end
            default: begin
                if (ioctl_download)  w_next_state = c_st_load;
                else if (user_reset) w_next_state = c_st_hold;
            end
        endcase
    end

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            r_state     <= c_st_idle;
            r_dl_d      <= 1'b0;
            r_index     <= 8'd0;
            r_hold_cnt  <= '0;
            r_last_seen <= 1'b0;
            r_overrun   <= 1'b0;
            rom_ok      <= 1'b0;
            rom_err     <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_dl_d      <= ioctl_download;
            r_index     <= w_cur_index;
            r_hold_cnt  <= ((r_state == c_st_hold) && (w_next_state == c_st_hold))
                           ? r_hold_cnt + 1'b1 : '0;
            r_last_seen <= (r_last_seen && !w_rom_start) || w_last_hit;
            r_overrun   <= (r_overrun && !w_rom_start) || w_overrun;
            if (w_rom_start) begin
                rom_ok  <= 1'b0;
                rom_err <= 1'b0;
            end else if ((r_state == c_st_load) && !ioctl_download && (r_index == ROM_INDEX)) begin
                rom_ok  <= w_load_good;
                rom_err <= !w_load_good;
            end
        end
    end

    // Write strobes are single-cycle pulses; address and data hold between them.
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            dn_addr <= 16'd0;
            dn_data <= 8'd0;
            cpu_we  <= 1'b0;
            gfx_we  <= 1'b0;
            prom_we <= 1'b0;
        end else begin
            cpu_we  <= 1'b0;
            gfx_we  <= 1'b0;
            prom_we <= 1'b0;
            if (w_rom_wr && w_in_image) begin
                dn_data <= ioctl_dout;
                if (w_a < CPU_END) begin
                    cpu_we  <= 1'b1;
                    dn_addr <= w_a;
                end else if (w_a < GFX_END) begin
                    gfx_we  <= 1'b1;
                    dn_addr <= w_a - CPU_END;
                end else begin
                    prom_we <= 1'b1;
                    dn_addr <= w_a - GFX_END;
                end
            end
        end
    end

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            mod_id  <= 8'd0;
            sw_flat <= 64'd0;
        end else begin
            if (w_wr && (w_cur_index == MOD_INDEX)) mod_id <= ioctl_dout;
            if (w_wr && (w_cur_index == DIP_INDEX) && (ioctl_addr[24:3] == '0))
                sw_flat[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_galaxian_load_ctrl.sv
`default_nettype none
// Testbench for galaxian_load_ctrl: directed scenarios plus randomized downloads,
// every cycle compared against a behavioural reference model.
module tb_galaxian_load_ctrl;

    localparam int RH     = 16;
    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_HOLD = 2;
    localparam int M_RUN  = 3;

    logic        clk_sys        = 1'b0;
    logic        RESET          = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr       = 1'b0;
    logic [7:0]  ioctl_index    = 8'd0;
    logic [24:0] ioctl_addr     = 25'd0;
    logic [7:0]  ioctl_dout     = 8'd0;
    logic        user_reset     = 1'b0;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        cpu_we, gfx_we, prom_we;
    logic [7:0]  mod_id;
    logic [63:0] sw_flat;
    logic        core_reset, rom_ok, rom_err;

    galaxian_load_ctrl #(.RESET_HOLD(RH)) dut (
        .clk_sys(clk_sys), .RESET(RESET), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .user_reset(user_reset), .dn_addr(dn_addr),
        .dn_data(dn_data), .cpu_we(cpu_we), .gfx_we(gfx_we), .prom_we(prom_we),
        .mod_id(mod_id), .sw_flat(sw_flat), .core_reset(core_reset),
        .rom_ok(rom_ok), .rom_err(rom_err)
    );

    initial forever #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          cyc = 0;
    int          m_mode = M_IDLE;
    int          m_release = 0;
    logic        m_dl_prev = 1'b0;
    logic [7:0]  m_idx = 8'd0;
    logic        m_saw = 1'b0, m_over = 1'b0;
    logic        m_ok = 1'b0, m_err = 1'b0;
    logic [7:0]  m_mod = 8'd0;
    logic [63:0] m_sw = 64'd0;
    logic [15:0] m_dn_addr = 16'd0;
    logic [7:0]  m_dn_data = 8'd0;
    logic        m_cpu = 1'b0, m_gfx = 1'b0, m_prom = 1'b0;

    task automatic model_step();
        logic [7:0]  idx;
        logic [15:0] a;
        cyc++;
        m_cpu = 1'b0; m_gfx = 1'b0; m_prom = 1'b0;
        if (RESET) begin
            m_mode = M_IDLE; m_ok = 1'b0; m_err = 1'b0; m_mod = 8'd0; m_sw = 64'd0;
            m_dn_addr = 16'd0; m_dn_data = 8'd0; m_dl_prev = 1'b0; m_idx = 8'd0;
            m_saw = 1'b0; m_over = 1'b0;
            return;
        end
        idx = (ioctl_download && !m_dl_prev) ? ioctl_index : m_idx;
        if (ioctl_download && m_mode != M_LOAD && idx == 8'd0) begin
            m_ok = 1'b0; m_err = 1'b0; m_saw = 1'b0; m_over = 1'b0;
        end
        if (ioctl_download && ioctl_wr) begin
            if (idx == 8'd0) begin
                if (ioctl_addr >= 25'h5020) m_over = 1'b1;
                else begin
                    a = ioctl_addr[15:0];
                    if (a == 16'h501F) m_saw = 1'b1;
                    m_dn_data = ioctl_dout;
                    if (a < 16'h4000)      begin m_cpu  = 1'b1; m_dn_addr = a; end
                    else if (a < 16'h5000) begin m_gfx  = 1'b1; m_dn_addr = a - 16'h4000; end
                    else                   begin m_prom = 1'b1; m_dn_addr = a - 16'h5000; end
                end
            end else if (idx == 8'd1) begin
                m_mod = ioctl_dout;
            end else if (idx == 8'd254 && ioctl_addr < 25'd8) begin
                m_sw[ioctl_addr[2:0]*8 +: 8] = ioctl_dout;
            end
        end
        case (m_mode)
            M_IDLE: if (ioctl_download) m_mode = M_LOAD;
            M_LOAD: if (!ioctl_download) begin
                if (idx == 8'd0) begin
                    m_ok  = m_saw && !m_over;
                    m_err = !m_ok;
                end
                if (m_ok) begin m_mode = M_HOLD; m_release = cyc + RH; end
                else m_mode = M_IDLE;
            end
            M_HOLD: begin
                if (ioctl_download) m_mode = M_LOAD;
                else if (cyc == m_release) m_mode = M_RUN;
            end
            default: begin
                if (ioctl_download) m_mode = M_LOAD;
                else if (user_reset) begin m_mode = M_HOLD; m_release = cyc + RH; end
            end
        endcase
        m_idx = idx;
        m_dl_prev = ioctl_download;
    endtask

    initial forever begin
        @(posedge clk_sys);
        model_step();
    end

    int n_cpu = 0, n_gfx = 0, n_prom = 0;

    initial forever begin
        @(posedge clk_sys);
        #2;
        chk("core_reset", core_reset, m_mode != M_RUN);
        chk("rom_ok", rom_ok, m_ok);
        chk("rom_err", rom_err, m_err);
        chk("cpu_we", cpu_we, m_cpu);
        chk("gfx_we", gfx_we, m_gfx);
        chk("prom_we", prom_we, m_prom);
        chk("dn_addr", dn_addr, m_dn_addr);
        chk("dn_data", dn_data, m_dn_data);
        chk("mod_id", mod_id, m_mod);
        chk("sw_flat", sw_flat, m_sw);
        if (cpu_we)  n_cpu++;
        if (gfx_we)  n_gfx++;
        if (prom_we) n_prom++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk_sys);
    endtask

    task automatic start_dl(input logic [7:0] idx);
        tick();
        ioctl_wr = 1'b0; user_reset = 1'b0;
        ioctl_download = 1'b1; ioctl_index = idx;
        tick();
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        tick();
        ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            ioctl_wr = 1'b0;
        end
    endtask

    task automatic end_dl();
        tick();
        ioctl_wr = 1'b0; ioctl_download = 1'b0;
    endtask

    // Counts consecutive sampled cycles with core_reset high, starting at the next edge.
    task automatic measure_hold(input string name, input int pre);
        int n;
        n = pre;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk_sys); #3;
            if (core_reset) n++;
            else break;
        end
        chk(name, n, RH);
    endtask

    task automatic rand_idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            ioctl_wr = 1'b0; user_reset = 1'b0;
            case ($urandom_range(0, 7))
                0: user_reset = 1'b1;
                1: begin
                    ioctl_wr = 1'b1; ioctl_addr = 25'($urandom);
                    ioctl_dout = 8'($urandom); ioctl_index = 8'($urandom);
                end
                default: ;
            endcase
        end
        tick();
        ioctl_wr = 1'b0; user_reset = 1'b0;
    endtask

    task automatic rand_dl();
        logic [7:0]  idx;
        logic [24:0] a;
        int          n;
        bit          clean;
        case ($urandom_range(0, 4))
            0, 1:    idx = 8'd0;
            2:       idx = 8'd1;
            3:       idx = 8'd254;
            default: idx = 8'($urandom_range(2, 253));
        endcase
        clean = 1'($urandom_range(0, 1));
        n = $urandom_range(1, 24);
        start_dl(idx);
        for (int i = 0; i < n; i++) begin
            if (idx == 8'd0) begin
                if (clean) a = (i == n - 1) ? 25'h501F : 25'($urandom_range(0, 'h501F));
                else case ($urandom_range(0, 5))
                    0:       a = 25'h501F;
                    1:       a = 25'h5020 + 25'($urandom_range(0, 'hFFF));
                    2:       a = 25'h10000 | 25'($urandom_range(0, 'h5020));
                    3:       a = 25'($urandom);
                    default: a = 25'($urandom_range(0, 'h501F));
                endcase
            end else if (idx == 8'd254) a = 25'($urandom_range(0, 15));
            else a = 25'($urandom);
            wr_byte(a, 8'($urandom));
            if ($urandom_range(0, 3) == 0) idle_n($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) ioctl_index = 8'($urandom);
        end
        end_dl();
    endtask

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: run exceeded its cycle budget");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int hi, st, c0, g0, p0, pre;
        RESET = 1'b1;
        repeat (4) tick();
        @(posedge clk_sys); #3;
        chk("rst_core_reset", core_reset, 1'b1);
        chk("rst_rom_ok", rom_ok, 1'b0);
        chk("rst_sw_flat", sw_flat, 64'd0);
        chk("rst_strobes", {cpu_we, gfx_we, prom_we}, 3'b000);
        tick();
        RESET = 1'b0;

        // Idle after reset: held in reset, no strobes
        hi = 0; st = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk_sys); #3;
            if (core_reset) hi++;
            if (cpu_we || gfx_we || prom_we) st++;
        end
        chk("idle_core_reset_cycles", hi, 1000);
        chk("idle_strobes", st, 0);
        chk("idle_rom_ok", rom_ok, 1'b0);

        // Full ROM image
        start_dl(8'd0);
        c0 = n_cpu; g0 = n_gfx; p0 = n_prom;
        for (int a = 0; a < 'h5020; a++) begin
            wr_byte(25'(a), 8'(a ^ (a >> 8)));
            if (a == 'h4000) begin
                @(posedge clk_sys); #3;
                chk("first_gfx_we", gfx_we, 1'b1);
                chk("first_gfx_dn_addr", dn_addr, 16'h0000);
            end
            if (a == 'h501F) begin
                @(posedge clk_sys); #3;
                chk("last_prom_we", prom_we, 1'b1);
                chk("last_prom_dn_addr", dn_addr, 16'h001F);
                chk("last_prom_dn_data", dn_data, 8'h4F);
            end
        end
        end_dl();
        measure_hold("full_rom_hold_len", 0);
        chk("full_cpu_count", n_cpu - c0, 16384);
        chk("full_gfx_count", n_gfx - g0, 4096);
        chk("full_prom_count", n_prom - p0, 32);
        chk("full_rom_ok", rom_ok, 1'b1);
        chk("full_rom_err", rom_err, 1'b0);

        // DIP and game-select downloads while running
        start_dl(8'd254);
        chk("dip_dl_core_reset", core_reset, 1'b1);
        wr_byte(25'd2, 8'hA5);
        wr_byte(25'd9, 8'hFF);
        end_dl();
        measure_hold("dip_hold_len", 0);
        chk("dip_sw_flat", sw_flat, 64'h0000_0000_00A5_0000);
        chk("dip_rom_ok_kept", rom_ok, 1'b1);
        start_dl(8'd1);
        chk("mod_dl_core_reset", core_reset, 1'b1);
        wr_byte(25'h1234, 8'h0A);
        end_dl();
        measure_hold("mod_hold_len", 0);
        chk("mod_id_0a", mod_id, 8'h0A);

        // One-cycle user reset
        tick();
        user_reset = 1'b1;
        @(posedge clk_sys); #3;
        pre = core_reset ? 1 : 0;
        tick();
        user_reset = 1'b0;
        measure_hold("user_reset_hold_len", pre);

        // Download start and user reset together
        tick();
        ioctl_download = 1'b1; ioctl_index = 8'd1; user_reset = 1'b1;
        tick();
        user_reset = 1'b0;
        wr_byte(25'd0, 8'h55);
        end_dl();
        measure_hold("prio_hold_len", 0);
        chk("prio_mod_id", mod_id, 8'h55);

        // Short ROM image
        start_dl(8'd0);
        for (int a = 0; a < 'h4000; a++) wr_byte(25'(a), 8'(a));
        end_dl();
        hi = 0;
        repeat (50) begin
            @(posedge clk_sys); #3;
            if (core_reset) hi++;
        end
        chk("short_core_reset_cycles", hi, 50);
        chk("short_rom_err", rom_err, 1'b1);
        chk("short_rom_ok", rom_ok, 1'b0);

        // Overrun addresses
        start_dl(8'd0);
        wr_byte(25'h501F, 8'h11);
        wr_byte(25'h5020, 8'h22);
        @(posedge clk_sys); #3;
        chk("overrun_5020_no_strobe", {cpu_we, gfx_we, prom_we}, 3'b000);
        wr_byte(25'h10000, 8'h33);
        @(posedge clk_sys); #3;
        chk("overrun_10000_no_strobe", {cpu_we, gfx_we, prom_we}, 3'b000);
        end_dl();
        repeat (3) tick();
        chk("overrun_rom_err", rom_err, 1'b1);
        chk("overrun_rom_ok", rom_ok, 1'b0);
        chk("overrun_core_reset", core_reset, 1'b1);

        // Randomized traffic
        for (int it = 0; it < 60; it++) begin
            rand_dl();
            rand_idle($urandom_range(0, 30));
        end

        // RESET in the middle of a ROM download
        start_dl(8'd0);
        wr_byte(25'h0000, 8'h01);
        wr_byte(25'h0001, 8'h02);
        tick();
        ioctl_wr = 1'b0; RESET = 1'b1;
        @(posedge clk_sys); #3;
        chk("midreset_core_reset", core_reset, 1'b1);
        chk("midreset_rom_ok", rom_ok, 1'b0);
        chk("midreset_sw_flat", sw_flat, 64'd0);
        chk("midreset_mod_id", mod_id, 8'd0);
        tick();
        ioctl_download = 1'b0;
        tick();
        RESET = 1'b0;
        idle_n(20);
        chk("after_reset_core_reset", core_reset, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
